// File: rtl/pipe_cla_adder.sv
// rtl/pipe_cla_adder.sv - Pipelined carry-lookahead adder/subtractor, one GRP-bit group per stage
// Operands not yet consumed ride down the pipe with their transaction, shrinking by GRP bits per stage.
module pipe_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_i,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             c_o,
  output logic             ovf
);

  localparam int STAGES = WIDTH / GRP;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign in_ready = !(out_valid && !out_ready);
  assign adv      = in_ready;
  assign b_eff    = sub ? ~B : B;
  assign c_eff    = sub | c_i;

  // Returns {carry_out, sum} of one group using fully expanded lookahead carries.
  function automatic logic [GRP:0] cla(input logic [GRP-1:0] a, input logic [GRP-1:0] b,
                                       input logic cin);
    logic [GRP-1:0] g;
    logic [GRP-1:0] p;
    logic [GRP:0]   c;
    logic           term;
    logic           pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GRP; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & cin);
    end
    return {c[GRP], p ^ c[GRP-1:0]};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int INW = WIDTH - k * GRP;
    localparam int REM = INW - GRP;

    logic [INW-1:0]         in_a;
    logic [INW-1:0]         in_b;
    logic                   in_c;
    logic                   in_v;
    logic                   in_sa;
    logic                   in_sb;
    logic [GRP:0]           grp_res;
    logic                   v_q;
    logic                   c_q;
    logic [(k+1)*GRP-1:0]   s_q;
    logic [(k+1)*GRP-1:0]   s_d;

    if (k == 0) begin : g_src
      assign in_a  = A;
      assign in_b  = b_eff;
      assign in_c  = c_eff;
      assign in_v  = in_valid;
      assign in_sa = A[WIDTH-1];
      assign in_sb = b_eff[WIDTH-1];
      assign s_d   = grp_res[GRP-1:0];
    end else begin : g_src
      assign in_a  = g_stage[k-1].g_rem.ra_q;
      assign in_b  = g_stage[k-1].g_rem.rb_q;
      assign in_c  = g_stage[k-1].c_q;
      assign in_v  = g_stage[k-1].v_q;
      assign in_sa = g_stage[k-1].g_rem.sa_q;
      assign in_sb = g_stage[k-1].g_rem.sb_q;
      assign s_d   = {grp_res[GRP-1:0], g_stage[k-1].s_q};
    end

    assign grp_res = cla(in_a[GRP-1:0], in_b[GRP-1:0], in_c);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= in_v;
        c_q <= grp_res[GRP];
        s_q <= s_d;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] ra_q;
      logic [REM-1:0] rb_q;
      logic           sa_q;
      logic           sb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
          sa_q <= 1'b0;
          sb_q <= 1'b0;
        end else if (adv) begin
          ra_q <= in_a[INW-1:GRP];
          rb_q <= in_b[INW-1:GRP];
          sa_q <= in_sa;
          sb_q <= in_sb;
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (in_sa == in_sb) && (grp_res[GRP-1] != in_sa);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign Sum       = g_stage[STAGES-1].s_q;
  assign c_o       = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
